fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory and feeds the decode stage.
- Owns the program counter and drives it to the instruction memory address input (byte address; the memory indexes words with A[31:2]).
- Registers the returned instruction word (combinational read) into the IF/ID pipeline register.
- Handles stall from hazard logic and redirect (taken branch/jump) from execute.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, bubble word (addi x0,x0,0) placed in IF/ID on reset, flush and halt.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset; sampled on posedge clk, overrides every other input.
stall  input  1  hold PC and IF/ID contents this cycle.
redirect  input  1  taken branch/jump; load redirect_target and flush IF/ID.
redirect_target  input  32  new PC byte address.
imem_addr  output  32  byte address to instruction memory A; equals current PC.
imem_rd  input  32  instruction word returned by instruction memory RD for imem_addr, same cycle.
ifid_instr  output  32  registered instruction.
ifid_pc  output  32  PC of ifid_instr.
ifid_pc_plus4  output  32  ifid_pc + 4.
ifid_valid  output  1  ifid_instr is a real fetched instruction, not a bubble.
fetch_count  output  32  number of instructions accepted into IF/ID.
halted  output  1  fetch frozen on EBREAK (FETCH_HALT_EN only; tied 0 otherwise).

Behaviour:
- All outputs are registered except imem_addr, which is a direct copy of the PC register.
- Reset values (rst=1 at posedge):
  - pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=0.
  - ifid_valid=0, fetch_count=0, halted=0, state=BOOT.
- FSM states: BOOT, RUN, HALT (HALT exists only with FETCH_HALT_EN).
- BOOT: lasts exactly one cycle after rst deasserts.
  - pc is held; IF/ID keeps its reset values.
  - stall and redirect are ignored.
  - Next state is RUN.
- RUN: per cycle, priority redirect > stall > advance.
  - redirect=1: pc <= {redirect_target[31:2],2'b00} (low bits forced to 0, no trap); ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc and ifid_pc_plus4 hold; fetch_count holds.
  - stall=1 (redirect=0): pc, all IF/ID fields and fetch_count hold; imem_rd is discarded.
  - advance: ifid_instr <= imem_rd; ifid_pc <= pc; ifid_pc_plus4 <= pc+4; ifid_valid <= 1; pc <= pc+4; fetch_count <= fetch_count+1.
- Latency: the word at PC p appears on ifid_instr one cycle after imem_addr=p, given no stall or redirect.
- Arithmetic: pc+4 and fetch_count are 32-bit and wrap modulo 2^32 with no flag (0xFFFFFFFC -> 0x00000000).
- Simultaneous redirect and stall: redirect wins and the flush happens.
- rst asserted mid-run: the next posedge applies all reset values regardless of stall, redirect or state, then BOOT.

Optional Feature:
Macro: FETCH_HALT_EN
- Defined:
  - In RUN on an advance cycle where imem_rd == 32'h00100073 (EBREAK), the EBREAK is captured normally (ifid_valid=1, fetch_count increments).
  - pc stays at the EBREAK address (no +4).
  - Next state is HALT and halted <= 1.
  - In HALT, each cycle: ifid_instr <= NOP_INSTR, ifid_valid <= 0, pc holds; stall and redirect are ignored. Only rst exits HALT.
  - A stalled EBREAK does not halt until it advances.
  - A redirect coinciding with an EBREAK on imem_rd wins, and no halt occurs.
- Undefined: EBREAK is fetched like any other word, HALT does not exist, and halted is constant 0.

Test Plan:
1. Memory words 0..7 = 0x11,0x22,...; pulse rst 2 cycles -> first cycle after release ifid_valid=0; next cycle ifid_pc=0, ifid_instr=0x11, ifid_pc_plus4=4; next ifid_pc=4, ifid_instr=0x22; fetch_count=2.
2. In RUN at pc=0x08, stall=1 for 3 cycles -> imem_addr stays 0x08; ifid_* and fetch_count unchanged; after release ifid_pc=0x08.
3. redirect=1, target=0x00000043 -> next cycle imem_addr=0x40, ifid_valid=0, ifid_instr=NOP_INSTR; following cycle ifid_pc=0x40, ifid_instr=word 16.
4. redirect=1 and stall=1 in the same cycle, target 0x20 -> flush and pc=0x20 (redirect wins); rst asserted while pc=0x24 -> next cycle pc=RESET_PC, ifid_valid=0, fetch_count=0.
5. RESET_PC=32'hFFFFFFFC, run 2 cycles -> imem_addr goes 0xFFFFFFFC then 0x00000000; ifid_pc_plus4=0x00000000 for the first instruction.
6. FETCH_HALT_EN defined, EBREAK at 0x0C -> ifid_pc=0x0C with ifid_valid=1 once, then halted=1, imem_addr stays 0x0C, ifid_valid=0 indefinitely; FETCH_HALT_EN undefined -> fetch continues at 0x10, halted=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Groups the fetch stage's control inputs, instruction-memory port and
//   IF/ID pipeline-register outputs into one bundle.
//
//   Signals:
//     stall, redirect, redirect_target : control from hazard/execute logic
//     imem_addr, imem_rd               : instruction memory address / data
//     ifid_instr, ifid_pc,
//     ifid_pc_plus4, ifid_valid        : IF/ID pipeline register
//     fetch_count                      : instructions accepted into IF/ID
//     halted                           : fetch frozen on EBREAK
//
//   Modports:
//     master : the fetch stage itself
//     slave  : the surrounding pipeline / memory side
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic        halted;

  modport master (
    input  stall,
    input  redirect,
    input  redirect_target,
    input  imem_rd,
    output imem_addr,
    output ifid_instr,
    output ifid_pc,
    output ifid_pc_plus4,
    output ifid_valid,
    output fetch_count,
    output halted
  );

  modport slave (
    output stall,
    output redirect,
    output redirect_target,
    output imem_rd,
    input  imem_addr,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_pc_plus4,
    input  ifid_valid,
    input  fetch_count,
    input  halted
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. Owns the program counter, presents it to the
//   instruction memory (combinational read) and captures the returned word
//   into the IF/ID pipeline register. Handles stall and redirect (flush).
//
//   Ports:
//     clk : single clock, all state updates on posedge
//     rst : synchronous active-high reset, overrides everything
//     bus : fetch_stage_if.master (control, imem port, IF/ID outputs)
//
//   Parameters:
//     RESET_PC  : PC loaded on reset
//     NOP_INSTR : bubble word placed in IF/ID on reset, flush and halt
//
//   Optional feature (macro FETCH_HALT_EN):
//     When defined, an EBREAK accepted into IF/ID freezes fetch in the HALT
//     state until reset. When undefined, EBREAK is an ordinary word and
//     halted is tied low.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] ifid_pc_reg, ifid_pc_next;
  logic [31:0] pc_plus4_reg, pc_plus4_next;
  logic        valid_reg, valid_next;
  logic [31:0] count_reg, count_next;
`ifdef FETCH_HALT_EN
  logic        halted_reg, halted_next;
`endif

  // Redirect targets are word aligned by discarding the low two bits.
  logic [1:0] unused_target_bits;
  assign unused_target_bits = bus.redirect_target[1:0];

  // Wraps modulo 2^32 with no flag.
  logic [31:0] pc_inc;
  assign pc_inc = pc_reg + 32'd4;

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_PC;
      instr_reg    <= NOP_INSTR;
      ifid_pc_reg  <= 32'h0;
      pc_plus4_reg <= 32'h0;
      valid_reg    <= 1'b0;
      count_reg    <= 32'h0;
`ifdef FETCH_HALT_EN
      halted_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      ifid_pc_reg  <= ifid_pc_next;
      pc_plus4_reg <= pc_plus4_next;
      valid_reg    <= valid_next;
      count_reg    <= count_next;
`ifdef FETCH_HALT_EN
      halted_reg   <= halted_next;
`endif
    end
  end

  // ---------------------------------------------------------------
  // Next-state / datapath logic. Everything holds unless a branch
  // below says otherwise.
  // ---------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    ifid_pc_next  = ifid_pc_reg;
    pc_plus4_next = pc_plus4_reg;
    valid_next    = valid_reg;
    count_next    = count_reg;
`ifdef FETCH_HALT_EN
    halted_next   = halted_reg;
`endif

    case (state_reg)
      // One dead cycle after reset: control inputs are ignored so the
      // first fetch always comes from RESET_PC.
      BOOT: begin
        state_next = RUN;
      end

      RUN: begin
        if (bus.redirect) begin
          // Flush: the in-flight word is wrong-path. ifid_pc and
          // ifid_pc_plus4 keep describing the last real instruction.
          pc_next    = {bus.redirect_target[31:2], 2'b00};
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end else if (!bus.stall) begin
          instr_next    = bus.imem_rd;
          ifid_pc_next  = pc_reg;
          pc_plus4_next = pc_inc;
          valid_next    = 1'b1;
          count_next    = count_reg + 32'd1;
`ifdef FETCH_HALT_EN
          // The EBREAK itself is delivered to decode; fetch then parks on
          // its address.
          if (bus.imem_rd == EBREAK_INSTR) begin
            state_next  = HALT;
            halted_next = 1'b1;
          end else begin
            pc_next = pc_inc;
          end
`else
          pc_next = pc_inc;
`endif
        end
      end

`ifdef FETCH_HALT_EN
      // Only reset leaves HALT; keep feeding bubbles downstream.
      HALT: begin
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
      end
`endif

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign bus.imem_addr     = pc_reg;
  assign bus.ifid_instr    = instr_reg;
  assign bus.ifid_pc       = ifid_pc_reg;
  assign bus.ifid_pc_plus4 = pc_plus4_reg;
  assign bus.ifid_valid    = valid_reg;
  assign bus.fetch_count   = count_reg;
`ifdef FETCH_HALT_EN
  assign bus.halted        = halted_reg;
`else
  assign bus.halted        = 1'b0;
`endif

endmodule
